// File: rtl/dma_write_burst.sv
// AXI4 write-DMA master: chops a byte-length transfer into INCR bursts that
// never cross a 4 KB page, streams data straight through, and tracks B responses.
module dma_write_burst #(
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int MAX_BURST_LEN      = 16,
   parameter int MAX_OUTSTANDING    = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            i_start,
   input  logic [31:0]                     i_base_addr,
   input  logic [31:0]                     i_byte_len,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_error,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_data,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]                      M_AXI_AWLEN,
   output logic [2:0]                      M_AXI_AWSIZE,
   output logic [1:0]                      M_AXI_AWBURST,
   output logic                            M_AXI_AWLOCK,
   output logic [3:0]                      M_AXI_AWCACHE,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic [3:0]                      M_AXI_AWQOS,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WLAST,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY
);

   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int LOG_B = $clog2(BYTES);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_WAIT_B, S_DONE} state_t;

   state_t                          state, state_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
   logic [31:0]                     rem_beats, cur_len, beat_cnt, burst_beats, page_beats, beats_total;
   logic [BYTES-1:0]                last_strb, strb_mask;
   logic [LOG_B-1:0]                rem_bytes;
   logic [32:0]                     len_round;
   logic [12:0]                     page_room;
   logic [3:0]                      outstanding, out_nxt;
   logic                            err;
   logic                            start_ok, misaligned, len_zero;
   logic                            aw_hs, w_beat, w_last_beat, burst_end, b_hs, final_burst;
   logic                            unused_ok;

   assign unused_ok   = ^{M_AXI_BID, M_AXI_BRESP[0]};

   assign start_ok    = (state == S_IDLE) && i_start;
   assign misaligned  = |i_base_addr[LOG_B-1:0];
   assign len_zero    = (i_byte_len == 32'd0);
   assign len_round   = {1'b0, i_byte_len} + 33'(BYTES - 1);
   assign beats_total = 32'(len_round >> LOG_B);
   assign rem_bytes   = i_byte_len[LOG_B-1:0];

   always_comb begin
      strb_mask = '0;
      for (int i = 0; i < BYTES; i++)
         strb_mask[i] = (rem_bytes == '0) || (LOG_B'(i) < rem_bytes);
   end

   // Beats left before the next 4 KB page; address is always beat-aligned here.
   assign page_room  = 13'h1000 - {1'b0, addr[11:0]};
   assign page_beats = 32'(page_room >> LOG_B);

   always_comb begin
      burst_beats = rem_beats;
      if (burst_beats > 32'(MAX_BURST_LEN)) burst_beats = 32'(MAX_BURST_LEN);
      if (burst_beats > page_beats)         burst_beats = page_beats;
   end

   assign aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_beat      = (state == S_W) & i_valid & M_AXI_WREADY;
   assign w_last_beat = (beat_cnt == cur_len - 32'd1);
   assign burst_end   = w_beat & w_last_beat;
   assign final_burst = (rem_beats == cur_len);
   assign b_hs        = M_AXI_BVALID & M_AXI_BREADY;

   always_comb begin
      out_nxt = outstanding;
      if (aw_hs && !b_hs)
         out_nxt = outstanding + 4'd1;
      else if (!aw_hs && b_hs && outstanding != 4'd0)
         out_nxt = outstanding - 4'd1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_start) state_nxt = (len_zero || misaligned) ? S_DONE : S_AW;
         S_AW:     if (aw_hs) state_nxt = S_W;
         S_W:      if (burst_end) state_nxt = final_burst ? S_WAIT_B : S_AW;
         S_WAIT_B: if (out_nxt == 4'd0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Everything data-dependent is gated by state so reset clears it at once.
   always_comb begin
      M_AXI_AWID    = '0;
      M_AXI_AWSIZE  = 3'(LOG_B);
      M_AXI_AWBURST = 2'b01;
      M_AXI_AWLOCK  = 1'b0;
      M_AXI_AWCACHE = 4'b0010;
      M_AXI_AWPROT  = 3'b000;
      M_AXI_AWQOS   = 4'b0000;
      M_AXI_AWVALID = (state == S_AW) && (outstanding < 4'(MAX_OUTSTANDING));
      M_AXI_AWADDR  = (state == S_AW) ? addr : '0;
      M_AXI_AWLEN   = (state == S_AW) ? 8'(burst_beats - 32'd1) : 8'd0;
      M_AXI_WVALID  = (state == S_W) && i_valid;
      M_AXI_WDATA   = (state == S_W) ? i_data : '0;
      M_AXI_WLAST   = (state == S_W) && w_last_beat;
      M_AXI_WSTRB   = '0;
      if (state == S_W)
         M_AXI_WSTRB = (final_burst && w_last_beat) ? last_strb : '1;
      o_ready       = (state == S_W) && M_AXI_WREADY;
      M_AXI_BREADY  = (state != S_IDLE);
      o_busy        = (state == S_AW) || (state == S_W) || (state == S_WAIT_B);
      o_done        = (state == S_DONE);
      o_error       = err;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         addr        <= '0;
         rem_beats   <= '0;
         cur_len     <= '0;
         beat_cnt    <= '0;
         last_strb   <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         outstanding <= out_nxt;
         if (start_ok) begin
            addr      <= C_M_AXI_ADDR_WIDTH'(i_base_addr);
            rem_beats <= beats_total;
            last_strb <= strb_mask;
            err       <= misaligned;
         end
         if (aw_hs) begin
            cur_len  <= burst_beats;
            beat_cnt <= '0;
         end else if (w_beat) begin
            beat_cnt <= beat_cnt + 32'd1;
         end
         if (burst_end) begin
            addr      <= addr + C_M_AXI_ADDR_WIDTH'(cur_len << LOG_B);
            rem_beats <= rem_beats - cur_len;
         end
         if (b_hs && M_AXI_BRESP[1]) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_write_burst.sv
// Directed bench for dma_write_burst: a burst/beat model built from the transfer
// rules is checked against the AXI traffic every cycle, plus literal pins.
module tb_dma_write_burst;

   localparam int MAXO = 2;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        i_start;
   logic [31:0] i_base_addr, i_byte_len;
   logic        o_busy, o_done, o_error;
   logic [31:0] i_data;
   logic        i_valid, o_ready;
   logic [0:0]  AWID;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWLOCK;
   logic [3:0]  AWCACHE;
   logic [2:0]  AWPROT;
   logic [3:0]  AWQOS;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST, WVALID, WREADY;
   logic [0:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;

   dma_write_burst #(
      .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .MAX_BURST_LEN(16), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_byte_len(i_byte_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
      .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
      .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
      .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

   aw_t exp_aw[$];
   w_t  exp_w[$];
   int  checks = 0, failures = 0;
   int  cyc = 0, aw_cnt = 0, b_cnt = 0, err_abs = -1;
   logic chk_en = 1'b0, b_en = 1'b1;
   logic aw_hs_q = 1'b0, w_hs_q = 1'b0, b_hs_q = 1'b0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Expected bursts and beats: split into beats, then take the largest burst
   // allowed by the beat limit and the bytes left in the current 4 KB page.
   task automatic build(input logic [31:0] base, input logic [31:0] len, input logic [31:0] dbase);
      longint left, a, n, room, k;
      aw_t aw; w_t w;
      exp_aw.delete(); exp_w.delete();
      left = (longint'(len) + 3) / 4;
      a = base; k = 0;
      while (left > 0) begin
         room = (4096 - (a % 4096)) / 4;
         n = left;
         if (n > 16) n = 16;
         if (n > room) n = room;
         aw.addr = 32'(a); aw.len = 8'(n - 1);
         exp_aw.push_back(aw);
         for (longint j = 0; j < n; j++) begin
            w.data = dbase + 32'(k);
            w.last = (j == n - 1);
            w.strb = ((left - j == 1) && (len % 4 != 0)) ? 4'((1 << (len % 4)) - 1) : 4'hF;
            exp_w.push_back(w);
            k++;
         end
         a = a + n * 4;
         left = left - n;
      end
   endtask

   // Compare process: every handshake is checked against the model queues.
   initial forever begin
      aw_t ea; w_t ew;
      @(negedge ACLK);
      aw_hs_q = AWVALID & AWREADY;
      w_hs_q  = WVALID & WREADY;
      b_hs_q  = BVALID & BREADY;
      if (chk_en) begin
         chk("aw_over_limit", AWVALID && ((aw_cnt - b_cnt) >= MAXO), 0);
         chk("ready_without_wready", o_ready & ~WREADY, 0);
         if (exp_aw.size() == 0) chk("aw_unexpected", AWVALID, 0);
         if (exp_w.size() == 0)  chk("w_unexpected", WVALID & WREADY, 0);
         if (aw_hs_q && exp_aw.size() > 0) begin
            ea = exp_aw.pop_front();
            chk("awaddr", AWADDR, ea.addr);
            chk("awlen", AWLEN, ea.len);
            chk("aw_4k_cross", (int'(AWADDR[11:0]) + (int'(AWLEN) + 1) * 4) > 4096, 0);
         end
         if (w_hs_q && exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            chk("wdata", WDATA, ew.data);
            chk("wstrb", WSTRB, ew.strb);
            chk("wlast", WLAST, ew.last);
         end
      end
      if (aw_hs_q) aw_cnt++;
      if (b_hs_q)  b_cnt++;
   end

   // Slave responder: patterned ready signals, B responses in AW order.
   initial begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
      forever begin
         @(posedge ACLK); #1;
         if (ARESETN) begin
            AWREADY = (cyc % 3 != 1);
            WREADY  = (cyc % 4 != 2);
            if (b_hs_q) BVALID = 0;
            if (!BVALID && b_en && (aw_cnt > b_cnt) && (cyc % 2 == 0)) begin
               BVALID = 1;
               BRESP  = (b_cnt == err_abs) ? 2'b10 : 2'b00;
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_awvalid"}, AWVALID, 0);   chk({tag, "_awaddr"}, AWADDR, 0);
      chk({tag, "_awlen"}, AWLEN, 0);       chk({tag, "_awburst"}, AWBURST, 2'b01);
      chk({tag, "_awcache"}, AWCACHE, 4'b0010);
      chk({tag, "_wvalid"}, WVALID, 0);     chk({tag, "_wdata"}, WDATA, 0);
      chk({tag, "_wstrb"}, WSTRB, 0);       chk({tag, "_wlast"}, WLAST, 0);
      chk({tag, "_bready"}, BREADY, 0);     chk({tag, "_ready"}, o_ready, 0);
      chk({tag, "_busy"}, o_busy, 0);       chk({tag, "_done"}, o_done, 0);
      chk({tag, "_error"}, o_error, 0);
   endtask

   task automatic run_xfer(input string nm, input logic [31:0] base, input logic [31:0] len,
                           input logic [31:0] dbase, input int errb, input int stall_k);
      int total, sent, aw0, b0;
      logic seen;
      total = exp_w.size(); aw0 = aw_cnt; b0 = b_cnt;
      err_abs = (errb > 0) ? b_cnt + errb - 1 : -1;
      b_en = (stall_k == 0);
      @(posedge ACLK); #1;
      i_base_addr = base; i_byte_len = len; i_start = 1; sent = 0; seen = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(posedge ACLK); #1;
         i_start = 0;
         if (k == 0) chk({nm, "_busy_next"}, o_busy, 1);
         if (w_hs_q) sent++;
         if (stall_k > 0 && k == stall_k) begin
            chk({nm, "_stalled_aw"}, aw_cnt - aw0, 2);
            chk({nm, "_stalled_busy"}, o_busy, 1);
            b_en = 1;
         end
         if (o_done) seen = 1;
         i_valid = (sent < total) && (cyc % 7 != 5);
         i_data  = dbase + 32'(sent);
      end
      i_valid = 0;
      chk({nm, "_done_seen"}, seen, 1);
      chk({nm, "_error"}, o_error, (errb > 0));
      chk({nm, "_busy_at_done"}, o_busy, 0);
      chk({nm, "_bursts_left"}, exp_aw.size(), 0);
      chk({nm, "_beats_left"}, exp_w.size(), 0);
      chk({nm, "_b_count"}, b_cnt - b0, aw_cnt - aw0);
      @(posedge ACLK); #1;
      chk({nm, "_done_one_cycle"}, o_done, 0);
   endtask

   task automatic short_start(input string nm, input logic [31:0] base, input logic [31:0] len,
                              input logic exp_err);
      exp_aw.delete(); exp_w.delete();
      @(posedge ACLK); #1;
      i_base_addr = base; i_byte_len = len; i_start = 1;
      @(posedge ACLK); #1;
      i_start = 0;
      chk({nm, "_done"}, o_done, 1);
      chk({nm, "_error"}, o_error, exp_err);
      chk({nm, "_busy"}, o_busy, 0);
      repeat (3) @(posedge ACLK);
      #1;
      chk({nm, "_done_clear"}, o_done, 0);
      chk({nm, "_error_sticky"}, o_error, exp_err);
   endtask

   initial begin
      int sent;
      logic fired;
      ARESETN = 0; i_start = 0; i_base_addr = 0; i_byte_len = 0; i_data = 0; i_valid = 0;
      #1;
      check_reset("rst_init");
      repeat (3) @(posedge ACLK);
      #2 ARESETN = 1;
      chk_en = 1;

      build(32'h1000, 256, 32'hA000_0000);
      chk("pin_t1_bursts", exp_aw.size(), 4);
      chk("pin_t1_addr3", exp_aw[3].addr, 32'h10C0);
      chk("pin_t1_len0", exp_aw[0].len, 15);
      chk("pin_t1_last16", exp_w[15].last, 1);
      chk("pin_t1_mid17", exp_w[16].last, 0);
      run_xfer("t1", 32'h1000, 256, 32'hA000_0000, 0, 0);

      build(32'h0FF8, 32, 32'hB000_0000);
      chk("pin_t2_len0", exp_aw[0].len, 1);
      chk("pin_t2_addr1", exp_aw[1].addr, 32'h1000);
      chk("pin_t2_len1", exp_aw[1].len, 5);
      run_xfer("t2", 32'h0FF8, 32, 32'hB000_0000, 0, 0);

      build(32'h5000, 10, 32'hC000_0000);
      chk("pin_t3_len", exp_aw[0].len, 2);
      chk("pin_t3_strb", exp_w[2].strb, 4'b0011);
      run_xfer("t3", 32'h5000, 10, 32'hC000_0000, 0, 0);

      build(32'h4000, 256, 32'hD000_0000);
      run_xfer("stall", 32'h4000, 256, 32'hD000_0000, 0, 150);

      build(32'h6000, 192, 32'hE000_0000);
      chk("pin_err_bursts", exp_aw.size(), 3);
      run_xfer("err", 32'h6000, 192, 32'hE000_0000, 2, 0);

      short_start("len0", 32'h2000, 0, 0);
      short_start("misalign", 32'h1002, 16, 1);

      // Reset dropped while a W beat is being offered.
      build(32'h7000, 256, 32'hF000_0000);
      b_en = 1; err_abs = -1;
      @(posedge ACLK); #1;
      i_base_addr = 32'h7000; i_byte_len = 256; i_start = 1;
      sent = 0; fired = 0;
      for (int k = 0; k < 2000 && !fired; k++) begin
         @(posedge ACLK); #1;
         i_start = 0;
         if (w_hs_q) sent++;
         i_valid = 1; i_data = 32'hF000_0000 + 32'(sent);
         @(negedge ACLK);
         if (sent >= 20 && WVALID && WREADY) begin
            chk_en = 0;
            ARESETN = 0;
            #1;
            check_reset("rst_midw");
            fired = 1;
         end
      end
      chk("rst_midw_reached", fired, 1);
      i_valid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
